// File: rtl/mcmem_pkg.sv
// Shared definitions for the multicycle CPU memory responder.
package mcmem_pkg;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned LANES       = 4;
  localparam int unsigned DEFAULT_LAT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/mcmem_array.sv
// Word-organised backing store: byte-enabled synchronous write, synchronous read-before-write.
module mcmem_array
  import mcmem_pkg::*;
#(
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];

  // Read samples the pre-write word since both updates are non-blocking.
  always_ff @(posedge clk) begin
    rdata <= mem[idx];
    for (int i = 0; i < int'(LANES); i++) begin
      if (we && be[i]) mem[idx][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
    end
  end
endmodule

// File: rtl/mcmem_responder.sv
// Memory-side responder: one request at a time, LAT wait states, single-cycle response pulse.
module mcmem_responder
  import mcmem_pkg::*;
#(
  parameter int unsigned AW  = 8,
  parameter int unsigned LAT = DEFAULT_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic        rd_live;
  logic [31:0] rdata_hold;
  logic [31:0] arr_rdata;

  logic        accept_c;
  logic        commit_c;
  logic        cur_we_c;
  logic [31:0] cur_addr_c;
  logic [31:0] cur_wdata_c;
  logic [3:0]  cur_be_c;
  logic        err_c;

  // With LAT==0 the commit happens on the accept edge, so it must use the live request.
  always_comb begin
    accept_c    = (state == IDLE) && req_valid;
    commit_c    = 1'b0;
    cur_we_c    = lat_we;
    cur_addr_c  = lat_addr;
    cur_wdata_c = lat_wdata;
    cur_be_c    = lat_be;
    if (state == IDLE) begin
      cur_we_c    = req_we;
      cur_addr_c  = req_addr;
      cur_wdata_c = req_wdata;
      cur_be_c    = req_be;
      commit_c    = accept_c && (LAT == 0);
    end else if (state == WAIT) begin
      commit_c = (cnt == 4'd0);
    end
    err_c = (cur_addr_c[1:0] != 2'd0) || ((cur_addr_c >> (AW + 2)) != 32'd0);
  end

  mcmem_array #(.AW(AW)) u_array (
    .clk   (clk),
    .we    (commit_c && cur_we_c && !err_c),
    .be    (cur_be_c),
    .idx   (cur_addr_c[AW+1:2]),
    .wdata (cur_wdata_c),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_be     <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rd_live    <= 1'b0;
      rdata_hold <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      // Freeze load data once the array read port moves on.
      if (rd_live) begin
        rdata_hold <= arr_rdata;
        rd_live    <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept_c) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            if (LAT == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LAT - 1);
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit_c) begin
        rsp_valid  <= 1'b1;
        rsp_err    <= err_c;
        rd_live    <= !cur_we_c && !err_c;
        rdata_hold <= 32'd0;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_rdata = rd_live ? arr_rdata : rdata_hold;
endmodule

// File: tb/tb_mcmem_responder.sv
// Directed bench for mcmem_responder with LAT=2 and LAT=0 instances.
module tb_mcmem_responder;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic        v0, we0, rdy0, rv0, re0;
  logic [31:0] addr0, wd0, rd0;
  logic [3:0]  be0;
  logic        v1, we1, rdy1, rv1, re1;
  logic [31:0] addr1, wd1, rd1;
  logic [3:0]  be1;

  always #5 clk = ~clk;

  mcmem_responder #(.AW(8), .LAT(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_we(we0), .req_addr(addr0),
    .req_wdata(wd0), .req_be(be0), .req_ready(rdy0), .rsp_valid(rv0),
    .rsp_rdata(rd0), .rsp_err(re0)
  );

  mcmem_responder #(.AW(8), .LAT(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_we(we1), .req_addr(addr1),
    .req_wdata(wd1), .req_be(be1), .req_ready(rdy1), .rsp_valid(rv1),
    .rsp_rdata(rd1), .rsp_err(re1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One LAT=2 transaction: checks ready, response latency, data, error and hold afterwards.
  task automatic req0(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] erd, input logic eerr,
                      input string tag);
    int n;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(rdy0), 32'd1);
    v0 = 1'b1; we0 = we; addr0 = a; wd0 = wd; be0 = be;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0; we0 = 1'b1; addr0 = 32'h0000_0010; wd0 = 32'hFFFF_FFFF; be0 = 4'hF;
    n = 0;
    while (rv0 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd2);
    chk({tag, "_rdata"}, rd0, erd);
    chk({tag, "_err"}, 32'(re0), 32'(eerr));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(rv0), 32'd0);
    chk({tag, "_hold"}, rd0, erd);
    chk({tag, "_rdy_back"}, 32'(rdy0), 32'd1);
  endtask

  initial begin
    int pulses;
    logic [31:0] pre_a [2];
    logic [31:0] pre_d [2];
    pre_a[0] = 32'h8;  pre_d[0] = 32'hA5A5_A5A5;
    pre_a[1] = 32'hC;  pre_d[1] = 32'h5A5A_0001;

    rst = 1'b1;
    v0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wd0 = 32'd0; be0 = 4'd0;
    v1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wd1 = 32'd0; be1 = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_valid", 32'(rv0), 32'd0);
    chk("rst_rdata", rd0, 32'd0);
    chk("rst_err", 32'(re0), 32'd0);
    rst = 1'b0;

    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (rv0 === 1'b1) pulses++;
    end
    chk("idle_no_rsp", 32'(pulses), 32'd0);

    req0(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "st_full");
    req0(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "ld_full");
    req0(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, "st_be");
    req0(1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0, "ld_be");
    req0(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, "ld_misalign");
    req0(1'b1, 32'h400, 32'h1234_5678, 4'hF, 32'h0, 1'b1, "st_range");
    req0(1'b1, 32'h10, 32'h9999_9999, 4'h0, 32'h0, 1'b0, "st_be0");
    req0(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, "ld_after_faults");

    // Reset during WAIT must drop the pending store.
    req0(1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0, "st_zero20");
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wd0 = 32'hCAFE_F00D; be0 = 4'hF;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("midwait_rst_ready", 32'(rdy0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (rv0 === 1'b1) pulses++;
    end
    chk("midwait_no_rsp", 32'(pulses), 32'd0);
    req0(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0, "ld_20");

    // LAT=0: preload, then two back-to-back loads with req_valid held.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      v1 = 1'b1; we1 = 1'b1; addr1 = pre_a[i]; wd1 = pre_d[i]; be1 = 4'hF;
      @(posedge clk);
      @(negedge clk);
      v1 = 1'b0;
      chk("l0_pre_valid", 32'(rv1), 32'd1);
      chk("l0_pre_err", 32'(re1), 32'd0);
    end
    @(negedge clk);
    v1 = 1'b1; we1 = 1'b0; addr1 = 32'h8;
    chk("l0_ready0", 32'(rdy1), 32'd1);
    @(negedge clk);
    chk("l0_rsp1_valid", 32'(rv1), 32'd1);
    chk("l0_rsp1_rdata", rd1, 32'hA5A5_A5A5);
    chk("l0_rsp1_ready", 32'(rdy1), 32'd0);
    addr1 = 32'hC;
    @(negedge clk);
    chk("l0_gap_valid", 32'(rv1), 32'd0);
    chk("l0_gap_ready", 32'(rdy1), 32'd1);
    chk("l0_gap_hold", rd1, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("l0_rsp2_valid", 32'(rv1), 32'd1);
    chk("l0_rsp2_rdata", rd1, 32'h5A5A_0001);
    chk("l0_rsp2_ready", 32'(rdy1), 32'd0);
    v1 = 1'b0;
    @(negedge clk);
    chk("l0_end_valid", 32'(rv1), 32'd0);
    chk("l0_end_ready", 32'(rdy1), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mcmem_responder.md
Name: mcmem_responder

Overview:
Memory-side responder for the multicycle CPU's load/store/fetch port. It accepts one request at a time from the CPU controller's memory stage. Each request is an instruction fetch, a data load or a data store. After a configurable number of wait states it returns a single-cycle response. It holds a word-organised backing store and checks alignment and range, so CPU stall logic can be exercised against a non-zero-latency memory.

Parameters:
AW, 8, word-address width; store holds 2**AW 32-bit words
LAT, 2, wait cycles between accept and response (0..15)

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  reset
req_valid  in  1  request present
req_we  in  1  1 = store, 0 = load/fetch
req_addr  in  32  byte address
req_wdata  in  32  store data
req_be  in  4  store byte enables, bit i -> bits [8i+7:8i]
req_ready  out  1  responder can accept this cycle
rsp_valid  out  1  response valid (one-cycle pulse)
rsp_rdata  out  32  load data, valid with rsp_valid
rsp_err  out  1  request faulted, valid with rsp_valid

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - On reset: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched request cleared.
  - Store contents are not cleared.
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE), combinational from state only.
- IDLE:
  - Accept on an edge with req_valid&req_ready; latch we, addr, wdata, be.
  - LAT==0: go to RESP and perform the commit on the same edge.
  - LAT>0: go to WAIT with counter=LAT-1.
- WAIT:
  - counter!=0: decrement.
  - counter==0: go to RESP and commit on that edge.
- Commit:
  - err = (addr[1:0]!=0) | (addr[31:AW+2]!=0).
  - Store without err: write bytes of mem[addr[AW+1:2]] selected by be; unselected bytes unchanged.
  - Load without err: rsp_rdata=mem[idx], the value before any same-edge write.
  - err: no write, rsp_rdata=0.
  - Store: rsp_rdata=0.
  - rsp_err=err, rsp_valid=1.
- RESP: outputs held for exactly one cycle. Next edge returns to IDLE with rsp_valid=0; rsp_rdata and rsp_err keep their values.
- Latency: accept edge E0; rsp_valid is high in the cycle after edge E0+LAT; req_ready rises after edge E0+LAT+1. Back-to-back accepts are LAT+2 edges apart.
- Request inputs are ignored outside IDLE; changes in WAIT do not affect the latched request.
- req_be is ignored for loads. req_be==0 on a store is a legal no-op write that still responds.
- Reset mid-WAIT drops the pending request and performs no write. Reset during RESP clears rsp_valid immediately.
- No backpressure on response: the requester must sample rsp_valid when it pulses.

Decomposition:
- Shared package mcmem_pkg:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - byte-lane width constant
  - default LAT
- Sub-module mcmem_array holds the 2**AW x 32 store:
  - synchronous byte-enabled write
  - synchronous read with read-before-write on the same edge
  - ports: clk, we, be, idx, wdata, rdata
- The responder owns the FSM, counter, latch and error logic.

Test Plan:
- Reset then idle: rst pulse -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; no response with req_valid=0.
- LAT=2 store/load: store addr 0x10, data 0xDEADBEEF, be=4'hF accepted at E0 -> rsp_valid only in the cycle after E2, rsp_err=0. Load addr 0x10 -> rsp_rdata=0xDEADBEEF after the same latency.
- Byte enables: store 0x11223344 be=4'b0101 over 0xDEADBEEF at 0x10 -> load returns 0xDE22BE44.
- Faults: load addr 0x13 -> rsp_err=1, rsp_rdata=0. Store to addr 0x400 with AW=8 -> rsp_err=1 and the store is unchanged.
- Reset mid-WAIT: store 0xCAFEF00D to 0x20 (prior 0x0) with rst asserted one cycle after accept -> no rsp_valid; a later load of 0x20 returns 0x0.
- LAT=0 throughput: two loads with req_valid held high -> rsp_valid after E0 and after E2, req_ready low exactly during the RESP cycles.
